// File: rtl/ddp_operand_loader.sv
// ddp_operand_loader
//
// Front-end feeder for the word-parallel compute stage of the RSA datapath.
// Words arrive over a valid/ready handshake. The first NWORDS words build
// operand A and the next NWORDS words build operand B, least-significant word
// first. The loader then pulses start for one cycle and holds both operands
// stable until the compute stage answers with done.
//
// Parameters:
//   WORD_W  width of one input word
//   NWORDS  words per operand (operand width = WORD_W*NWORDS)
//   CNT_W   width of the completed-operation counter
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   resetn     synchronous active-low reset
//   in_valid   input word valid
//   in_data    input word
//   in_ready   loader can accept a word this cycle
//   op_a       assembled operand A
//   op_b       assembled operand B
//   start      one-cycle pulse to the compute stage
//   done       completion pulse from the compute stage
//   busy       operands handed off, waiting for done
//   op_count   number of completed operations (wraps)
//
// Optional feature, enabled by defining LOADER_LAST_CHECK_EN:
//   in_last    marks the final word of a frame
//   frame_err  one-cycle pulse when a frame is discarded for bad framing
module ddp_operand_loader #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_data,
`ifdef LOADER_LAST_CHECK_EN
  input  logic                     in_last,
  output logic                     frame_err,
`endif
  output logic                     in_ready,
  output logic [WORD_W*NWORDS-1:0] op_a,
  output logic [WORD_W*NWORDS-1:0] op_b,
  output logic                     start,
  input  logic                     done,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int OPW = WORD_W * NWORDS;
  localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    START  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]   op_a_q, op_a_d;
  logic [OPW-1:0]   op_b_q, op_b_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             xfer;
  logic             last_word;
`ifdef LOADER_LAST_CHECK_EN
  logic             frame_err_q, frame_err_d;
`endif

  // Handshake outputs are forced low while resetn is asserted so the
  // upstream never sees a stale ready during reset.
  assign in_ready  = resetn && ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign busy      = resetn && ((state_q == START) || (state_q == WAIT));
  assign start     = resetn && (state_q == START);
  assign xfer      = in_valid && in_ready;
  assign last_word = (cnt_q == WORD_LAST);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_count  = op_count_q;
`ifdef LOADER_LAST_CHECK_EN
  assign frame_err = frame_err_q;
`endif

  // Next-state logic. New words enter at the top of the operand and
  // everything shifts down one word, so after NWORDS transfers the first
  // word lands in the least-significant position. The concatenate-then-shift
  // form stays legal even when NWORDS is 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_count_d = op_count_q;
`ifdef LOADER_LAST_CHECK_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      LOAD_A: begin
        if (xfer) begin
          op_a_d = OPW'({in_data, op_a_q} >> WORD_W);
          if (last_word) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + WCW'(1);
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          op_b_d = OPW'({in_data, op_b_q} >> WORD_W);
          if (last_word) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + WCW'(1);
          end
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = LOAD_A;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
`ifdef LOADER_LAST_CHECK_EN
    // in_last must appear on the final B word and nowhere else. A violation
    // throws the frame away and restarts collection of A; the partially
    // loaded operand bits are left as they are.
    if (xfer && (((state_q == LOAD_A) && in_last) ||
                 ((state_q == LOAD_B) && (in_last != last_word)))) begin
      frame_err_d = 1'b1;
      state_d     = LOAD_A;
      cnt_d       = '0;
    end
`endif
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_count_q <= '0;
`ifdef LOADER_LAST_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_count_q <= op_count_d;
`ifdef LOADER_LAST_CHECK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

endmodule
